// File: rtl/tinyrv_pkg.sv
// Shared constants, op encoding and sequencer state encoding for the byte-serial core.
package tinyrv_pkg;

  localparam int unsigned NREGS  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned NPHASE = 4;
  localparam int unsigned PW     = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_SLTU = 3'd6
  } op_e;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE = 2'd0;
  localparam seq_state_t ST_EXEC = 2'd1;
  localparam seq_state_t ST_FIX  = 2'd2;

  // Ops that feed the slice an inverted b operand with carry-in 1 at phase 0.
  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

  // Whether the byte computed in the given phase is written back to rd.
  function automatic logic op_writes(input logic [2:0] op, input logic [PW-1:0] phase,
                                     input logic slt_en);
    if (op <= OP_XOR) return 1'b1;
    if (slt_en && ((op == OP_SLT) || (op == OP_SLTU)) && (phase != '0)) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/rf_byte_alu.sv
// Combinational 8-bit ALU slice; chains across phases through cin/cout.
module rf_byte_alu
  import tinyrv_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  input  logic       cin,
  output logic [7:0] y,
  output logic       cout,
  output logic       y_sign
);

  logic [7:0] b_eff;
  logic [8:0] sum;

  always_comb begin
    b_eff = op_is_sub(op) ? ~b : b;
    sum   = 9'(a) + 9'(b_eff) + 9'(cin);
    y     = sum[7:0];
    cout  = sum[8];
    case (op)
      OP_AND: begin y = a & b; cout = 1'b0; end
      OP_OR:  begin y = a | b; cout = 1'b0; end
      OP_XOR: begin y = a ^ b; cout = 1'b0; end
      default: ;
    endcase
  end

  assign y_sign = y[7];

endmodule

// File: rtl/rf_byte_sequencer.sv
// Walks one ALU op across four byte phases of the register file, LSB first.
// Define RF_SEQ_SLT_EN to build SLT/SLTU support (extra FIX cycle writing the compare bit).
module rf_byte_sequencer
  import tinyrv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  input  logic [AW-1:0] req_rd,
  output logic          done,
  output logic          result_zero,
  output logic [PW-1:0] rf_phase,
  output logic [AW-1:0] rf_rs1,
  output logic [AW-1:0] rf_rs2,
  output logic [AW-1:0] rf_rd,
  input  logic [7:0]    rf_rs1_dat,
  input  logic [7:0]    rf_rs2_dat,
  output logic [7:0]    rf_rd_dat
);

`ifdef RF_SEQ_SLT_EN
  localparam logic SLT_EN = 1'b1;
`else
  localparam logic SLT_EN = 1'b0;
`endif

  seq_state_t    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rs1_q, rs1_d;
  logic [AW-1:0] rs2_q, rs2_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rf_rd_q, rf_rd_d;
  logic          carry_q, carry_d;
  logic          zacc_q, zacc_d;
  logic          lt_q, lt_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          rzero_q, rzero_d;

  logic [7:0]    alu_y;
  logic          alu_cout;
  logic          alu_sign;
  logic          alu_cin_c;
  logic          slt_op_c;
  logic          last_phase_c;
  logic          byte_zero_c;

  assign slt_op_c     = SLT_EN && ((op_q == OP_SLT) || (op_q == OP_SLTU));
  assign last_phase_c = (phase_q == PW'(NPHASE - 1));
  assign byte_zero_c  = (alu_y == 8'h00);
  // Carry is cleared on accept, so only subtract forms need a forced carry-in at phase 0.
  assign alu_cin_c    = ((phase_q == '0) && op_is_sub(op_q)) ? 1'b1 : carry_q;

  rf_byte_alu u_alu (
    .a      (rf_rs1_dat),
    .b      (rf_rs2_dat),
    .op     (op_q),
    .cin    (alu_cin_c),
    .y      (alu_y),
    .cout   (alu_cout),
    .y_sign (alu_sign)
  );

  // Next-state, datapath latches and registered outputs.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rf_rd_d = '0;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    lt_d    = lt_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    rzero_d = rzero_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          state_d = ST_EXEC;
          phase_d = '0;
          op_d    = req_op;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rd_d    = req_rd;
          carry_d = 1'b0;
          zacc_d  = 1'b1;
          ready_d = 1'b0;
          rf_rd_d = op_writes(req_op, '0, SLT_EN) ? req_rd : '0;
        end
      end
      ST_EXEC: begin
        carry_d = alu_cout;
        zacc_d  = zacc_q & byte_zero_c;
        if (last_phase_c) begin
          phase_d = '0;
          if (slt_op_c) begin
            state_d = ST_FIX;
            rf_rd_d = rd_q;
            // Signed compare falls back to the difference sign only when operand signs match.
            if (op_q == OP_SLTU) lt_d = ~alu_cout;
            else lt_d = (rf_rs1_dat[7] != rf_rs2_dat[7]) ? rf_rs1_dat[7] : alu_sign;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            rzero_d = (op_q <= OP_XOR) && zacc_q && byte_zero_c;
          end
        end else begin
          phase_d = phase_q + PW'(1);
          rf_rd_d = op_writes(op_q, phase_q + PW'(1), SLT_EN) ? rd_q : '0;
        end
      end
`ifdef RF_SEQ_SLT_EN
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        ready_d = 1'b1;
        rzero_d = zacc_q;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rf_rd_q <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      lt_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      rzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rf_rd_q <= rf_rd_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      lt_q    <= lt_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      rzero_q <= rzero_d;
    end
  end

  // Write byte follows the file's combinational read in the same cycle.
  always_comb begin
    rf_rd_dat = alu_y;
    if (state_q == ST_FIX) rf_rd_dat = {7'b0, lt_q};
    else if (slt_op_c) rf_rd_dat = 8'h00;
  end

  assign req_ready   = ready_q;
  assign done        = done_q;
  assign result_zero = rzero_q;
  assign rf_phase    = phase_q;
  assign rf_rs1      = rs1_q;
  assign rf_rs2      = rs2_q;
  assign rf_rd       = rf_rd_q;

endmodule

// File: tb/tb_rf_byte_sequencer.sv
// Bench for rf_byte_sequencer: byte-sliced register file model, vector table, random ops vs. a word-level model.
module tb_rf_byte_sequencer;

`ifdef RF_SEQ_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR = 3'd3,
                         T_XOR = 3'd4, T_SLT = 3'd5, T_SLTU = 3'd6, T_RSV = 3'd7;
  localparam int L6 = SLT_EN ? 6 : 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic [3:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic       done, result_zero;
  logic [1:0] rf_phase;
  logic [3:0] rf_rs1, rf_rs2, rf_rd;
  logic [7:0] rf_rs1_dat, rf_rs2_dat, rf_rd_dat;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rf_byte_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .done(done), .result_zero(result_zero), .rf_phase(rf_phase),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_rs1_dat(rf_rs1_dat), .rf_rs2_dat(rf_rs2_dat), .rf_rd_dat(rf_rd_dat)
  );

  // Register file: x0 reads 0, writes every edge to byte rf_phase of rf_rd; preload port for setup.
  logic [31:0] regs [16] = '{default: 32'h0};
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] rs1_w, rs2_w;

  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_addr != 4'd0) regs[pl_addr] <= pl_data;
    end else if (rf_rd != 4'd0) begin
      regs[rf_rd][{rf_phase, 3'b000} +: 8] <= rf_rd_dat;
    end
  end

  always_comb begin
    rs1_w = (rf_rs1 == 4'd0) ? 32'h0 : regs[rf_rs1];
    rs2_w = (rf_rs2 == 4'd0) ? 32'h0 : regs[rf_rs2];
    rf_rs1_dat = rs1_w[{rf_phase, 3'b000} +: 8];
    rf_rs2_dat = rs2_w[{rf_phase, 3'b000} +: 8];
  end

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  rs1, rs2, rd;
    logic [31:0] a, b, pre, exp;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pre, input logic [31:0] exp, input logic zero,
                              input int lat);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.a = a; v.b = b;
    v.pre = pre; v.exp = exp; v.zero = zero; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] read_reg(input logic [3:0] a);
    return (a == 4'd0) ? 32'h0 : regs[a];
  endfunction

  function automatic bit is_cmp(input logic [2:0] op);
    return SLT_EN && ((op == T_SLT) || (op == T_SLTU));
  endfunction

  // Word-level reference: the value an op leaves in rd.
  function automatic logic [31:0] ref_val(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      T_ADD:  return a + b;
      T_SUB:  return a - b;
      T_AND:  return a & b;
      T_OR:   return a | b;
      T_XOR:  return a ^ b;
      T_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      T_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  // Expected rf_rd in cycle cyc after acceptance (1..4 = phases, 5 = compare fix-up).
  function automatic logic [3:0] exp_rd_at(input logic [2:0] op, input logic [3:0] rd, input int cyc);
    if (op <= T_XOR) return (cyc <= 4) ? rd : 4'd0;
    if (is_cmp(op)) return (cyc >= 2 && cyc <= 5) ? rd : 4'd0;
    return 4'd0;
  endfunction

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [3:0] rd, input logic [31:0] exp_val,
                        input logic exp_zero, input int exp_lat);
    int  cyc;
    bit  seen, seq_ok;
    @(negedge clk);
    chk({nm, ":ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; seen = 1'b0; seq_ok = 1'b1;
    while (!seen && cyc <= 12) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (rf_phase != ((cyc <= 4) ? 2'(cyc - 1) : 2'd0)) seq_ok = 1'b0;
        if (rf_rd != exp_rd_at(op, rd, cyc)) seq_ok = 1'b0;
        if (cyc <= 4 && (rf_rs1 != rs1 || rf_rs2 != rs2)) seq_ok = 1'b0;
        if (req_ready) seq_ok = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    chk({nm, ":latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({nm, ":rf_seq"}, 32'(seq_ok), 32'd1);
    chk({nm, ":result_zero"}, 32'(result_zero), 32'(exp_zero));
    chk({nm, ":rd_value"}, read_reg(rd), exp_val);
    @(negedge clk);
    chk({nm, ":done_pulse"}, {31'b0, done, rf_rd}, 32'd0);
  endtask

  initial begin
    int cyc, low;
    bit seen;
    logic [2:0]  op;
    logic [3:0]  rs1, rs2, rd;
    logic [31:0] a, b, pre, exp;
    logic        ez;

    vecs.push_back(mk(T_ADD,  1, 2, 3, 32'h0000_00FF, 32'h0000_0001, 32'h0, 32'h0000_0100, 1'b0, 5));
    vecs.push_back(mk(T_SUB,  1, 1, 4, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 1'b1, 5));
    vecs.push_back(mk(T_SLT,  1, 2, 5, 32'hFFFF_FFFF, 32'h1, 32'hDEAD_BEEF,
                      SLT_EN ? 32'h1 : 32'hDEAD_BEEF, 1'b0, L6));
    vecs.push_back(mk(T_SLTU, 1, 2, 5, 32'hFFFF_FFFF, 32'h1, 32'hDEAD_BEEF,
                      SLT_EN ? 32'h0 : 32'hDEAD_BEEF, 1'b0, L6));
    vecs.push_back(mk(T_ADD,  1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 1'b0, 5));
    vecs.push_back(mk(T_ADD,  1, 1, 1, 32'h8080_8080, 32'h8080_8080, 32'h0, 32'h0101_0100, 1'b0, 5));
    vecs.push_back(mk(T_AND,  1, 2, 6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000, 1'b0, 5));
    vecs.push_back(mk(T_OR,   1, 2, 7, 32'h0F0F_0000, 32'h00F0_00F0, 32'h0, 32'h0FFF_00F0, 1'b0, 5));
    vecs.push_back(mk(T_XOR,  1, 2, 8, 32'hAAAA_5555, 32'hAAAA_5555, 32'h1234, 32'h0, 1'b1, 5));
    vecs.push_back(mk(T_RSV,  1, 2, 9, 32'h1, 32'h2, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 5));
    vecs.push_back(mk(T_SUB,  1, 2, 10, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0, 5));
    vecs.push_back(mk(T_ADD,  1, 2, 10, 32'hFFFF_FFFF, 32'h1, 32'h7, 32'h0, 1'b1, 5));
    vecs.push_back(mk(T_SLT,  1, 2, 5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,
                      SLT_EN ? 32'h1 : 32'h0, 1'b0, L6));
    vecs.push_back(mk(T_SLT,  1, 2, 5, 32'h5, 32'h5, 32'h9, SLT_EN ? 32'h0 : 32'h9, SLT_EN, L6));
    vecs.push_back(mk(T_SLTU, 1, 2, 5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7,
                      SLT_EN ? 32'h0 : 32'h7, 1'b0, L6));
    vecs.push_back(mk(T_SLT,  1, 2, 1, 32'h1, 32'h2, 32'h0, 32'h1, 1'b0, L6));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst:req_ready", 32'(req_ready), 32'd1);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:result_zero", 32'(result_zero), 32'd0);
    chk("rst:rf_phase", 32'(rf_phase), 32'd0);
    chk("rst:rf_rs1", 32'(rf_rs1), 32'd0);
    chk("rst:rf_rs2", 32'(rf_rs2), 32'd0);
    chk("rst:rf_rd", 32'(rf_rd), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      preload(vecs[i].rd, vecs[i].pre);
      preload(vecs[i].rs1, vecs[i].a);
      preload(vecs[i].rs2, vecs[i].b);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
             vecs[i].exp, vecs[i].zero, vecs[i].lat);
    end

    // Back-to-back: second request held valid while busy, accepted in the done cycle.
    preload(4'd1, 32'd5);
    preload(4'd2, 32'd7);
    preload(4'd3, 32'd100);
    @(negedge clk);
    req_valid = 1'b1; req_op = T_ADD; req_rs1 = 4'd1; req_rs2 = 4'd2; req_rd = 4'd12;
    @(negedge clk);
    req_op = T_SUB; req_rs1 = 4'd3; req_rs2 = 4'd1; req_rd = 4'd13;
    cyc = 1; low = 0; seen = 1'b0;
    while (!seen && cyc <= 12) begin
      if (done) seen = 1'b1;
      else begin
        if (!req_ready) low++;
        @(negedge clk);
        cyc++;
      end
    end
    chk("b2b:ready_low_cycles", 32'(low), 32'd4);
    chk("b2b:first_latency", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'd5);
    chk("b2b:ready_in_done", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("b2b:accepted", {23'b0, req_ready, rf_rs1, rf_rs2}, {23'b0, 1'b0, 4'd3, 4'd1});
    req_valid = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc <= 12) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("b2b:second_latency", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'd5);
    chk("b2b:first_value", read_reg(4'd12), 32'd12);
    chk("b2b:second_value", read_reg(4'd13), 32'd95);

    // Reset during phase 2: bytes 0..2 already written, no done pulse.
    preload(4'd11, 32'hCAFE_BABE);
    preload(4'd14, 32'h1122_3344);
    preload(4'd15, 32'h0101_0101);
    @(negedge clk);
    req_valid = 1'b1; req_op = T_ADD; req_rs1 = 4'd14; req_rs2 = 4'd15; req_rd = 4'd11;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid:phase2", 32'(rf_phase), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid:idle", {30'b0, req_ready, done}, {30'b0, 1'b1, 1'b0});
    chk("rstmid:rf_rd", 32'(rf_rd), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rstmid:no_done", 32'(seen), 32'd0);
    chk("rstmid:partial_write", read_reg(4'd11), 32'hCA23_3445);
    run_op("rstmid:next", T_ADD, 4'd14, 4'd15, 4'd11, 32'h1223_3445, 1'b0, 5);

    // Random ops against the word-level model.
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 7));
      rs1 = 4'($urandom_range(0, 15));
      rs2 = 4'($urandom_range(0, 15));
      rd  = 4'($urandom_range(0, 15));
      preload(rd, $urandom);
      preload(rs1, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      preload(rs2, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      a   = read_reg(rs1);
      b   = read_reg(rs2);
      pre = read_reg(rd);
      if (op <= T_XOR || is_cmp(op)) exp = ref_val(op, a, b);
      else exp = pre;
      if (rd == 4'd0) exp = 32'h0;
      if (op <= T_XOR) ez = (ref_val(op, a, b) == 32'h0);
      else if (is_cmp(op)) ez = (a == b);
      else ez = 1'b0;
      run_op($sformatf("rnd%0d_op%0d", n, op), op, rs1, rs2, rd, exp, ez, is_cmp(op) ? 6 : 5);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
